dap_resp_framer: RTL
====================

// Module: dap_resp_framer
// PURPOSE
//  Upstream stage of the DAP USB IN packer. Takes the byte stream produced by the DAP command
//  handlers and writes it into the packer RAM with group-relative addresses. Issues group_finish
//  after each command response and packet_finish after each complete DAP response packet.
//  Holds off new packets while the packer queue is almost full.
// PARAMETERS
//  MAX_PKT_LEN  512  max bytes per DAP response packet; must be <=1023 (10-bit length)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous reset, active-high
//  s_data          in   8   response byte
//  s_valid         in   1   s_data valid
//  s_ready         out  1   byte accepted when s_valid & s_ready
//  s_group_last    in   1   with the accepted byte: last byte of one command response
//  s_packet_last   in   1   with the accepted byte: last byte of the DAP packet (implies group_last)
//  ram_write_addr  out  10  byte offset from the current group head
//  ram_write_data  out  8   byte to write
//  ram_write_en    out  1   write strobe
//  packet_len      out  10  group byte count; valid while group_finish=1, otherwise 0
//  group_finish    out  1   1-cycle pulse: group complete
//  packet_finish   out  1   1-cycle pulse: packet complete
//  almost_full     in   1   packer queue nearly full
//  overflow        out  1   sticky: bytes dropped because the packet exceeded MAX_PKT_LEN
// BEHAVIOUR
//  - Reset: every output is 0 except s_ready. Counters clear and state goes to STREAM.
//    s_ready after reset is 1 if almost_full=0.
//  - All packer-side outputs are registered. A byte accepted in cycle N is written in cycle N+1
//    with ram_write_addr = grp_cnt (group byte index before the increment).
//  - States:
//    - STREAM: s_ready = !(pkt_cnt==0 && grp_cnt==0 && almost_full). Backpressure applies only
//      at a packet start; a packet already in progress is never stalled by almost_full.
//      Accepted byte with group_last=1 -> GFIN.
//    - GFIN (1 cycle): s_ready=0. group_finish=1 and packet_len=grp_cnt. This cycle may coincide
//      with the last byte's write, which is legal because the packer uses the old head for the
//      write. Then pkt_cnt += grp_cnt and grp_cnt=0. Next state is PFIN if packet_last was
//      latched, otherwise STREAM.
//    - PFIN (1 cycle): s_ready=0. packet_finish=1 and packet_len=0, so the packer tail equals
//      the head. Then pkt_cnt=0 -> STREAM.
//  - Latency: last byte accepted at N -> group_finish at N+1 -> packet_finish at N+2.
//    Next byte can be accepted at N+2 (group only) or N+3 (packet end).
//  - Limit: a byte is written only when pkt_cnt+grp_cnt < MAX_PKT_LEN. Excess bytes are still
//    accepted, which keeps the handshake alive, but are not written. grp_cnt does not increment
//    for them, and overflow is set to 1. Framing pulses still occur, with truncated lengths.
//  - group_last without packet_last on the byte that reaches the limit is framed normally.
//  - s_valid=0 mid-group: no writes, counters hold, no timeout.
//  - rst mid-packet: the partial packet is discarded and no pulses are emitted. The packer must
//    be reset together with this block.
//  - Widths: grp_cnt and pkt_cnt are 10-bit. The sum is compared in 11 bits, so there is no wrap.
// CONFIGURATION
//  - Macro DAP_FRAMER_STATS_EN.
//  - Defined: adds outputs stat_pkts[15:0] and stat_bytes[31:0]. Both are wrapping counters,
//    cleared by rst. stat_pkts increments on each packet_finish. stat_bytes adds packet_len on
//    each group_finish.
//  - Undefined: the ports and the logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package dap_usb_pkg holds:
//    - DAP_MAX_PKT_LEN_HS=512 and DAP_MAX_PKT_LEN_FS=64;
//    - the framer state enum {STREAM, GFIN, PFIN};
//    - the 10-bit dap_len_t typedef.
//  - Sub-module: dap_resp_framer_stats, instantiated only under DAP_FRAMER_STATS_EN.
//    No other split.
// TESTING
//  1. Single packet of one 3-byte group (0x00,0x01,0x02 with packet_last on 0x02):
//     - writes at addr 0,1,2;
//     - group_finish with packet_len=3 in the same cycle as the addr-2 write;
//     - packet_finish with packet_len=0 on the next cycle.
//  2. Packet of two groups (2 bytes + 4 bytes):
//     - addrs 0,1 then 0..3;
//     - group_finish lengths 2 then 4; one packet_finish; s_ready=0 during GFIN/PFIN.
//  3. almost_full=1 at idle:
//     - s_ready=0 and no writes;
//     - after almost_full drops, the first byte is accepted on the same cycle.
//     - almost_full rising mid-packet: s_ready stays 1.
//  4. MAX_PKT_LEN=64, 70-byte single group:
//     - 64 writes at addrs 0..63; all 70 bytes are accepted;
//     - packet_len=64 and overflow=1 remains set afterwards.
//  5. rst asserted after 5 bytes of a group:
//     - no group_finish or packet_finish is emitted;
//     - the next packet starts writing at addr 0 with overflow=0.
//  6. With DAP_FRAMER_STATS_EN: 3 packets of 10 bytes each -> stat_pkts=3, stat_bytes=30.

Source files
------------

// File: rtl/dap_usb_pkg.sv
// Shared types and limits for the DAP USB IN response path.
package dap_usb_pkg;
  localparam int DAP_MAX_PKT_LEN_HS = 512;
  localparam int DAP_MAX_PKT_LEN_FS = 64;

  typedef logic [9:0] dap_len_t;

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    GFIN   = 2'd1,
    PFIN   = 2'd2
  } framer_state_e;
endpackage

// File: rtl/dap_resp_framer_if.sv
// Byte-stream and packer-RAM signals of the DAP response framer.
// Handshake: a byte transfers on a clock edge where s_valid & s_ready are both 1;
// s_ready may depend on almost_full combinationally, s_valid must not depend on s_ready.
interface dap_resp_framer_if;
  import dap_usb_pkg::*;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_group_last;
  logic       s_packet_last;
  dap_len_t   ram_write_addr;
  logic [7:0] ram_write_data;
  logic       ram_write_en;
  dap_len_t   packet_len;
  logic       group_finish;
  logic       packet_finish;
  logic       almost_full;
  logic       overflow;
  logic [1:0] dbg_state;

  modport slave (
    input  s_data, s_valid, s_group_last, s_packet_last, almost_full,
    output s_ready, ram_write_addr, ram_write_data, ram_write_en,
           packet_len, group_finish, packet_finish, overflow, dbg_state
  );

  modport master (
    output s_data, s_valid, s_group_last, s_packet_last, almost_full,
    input  s_ready, ram_write_addr, ram_write_data, ram_write_en,
           packet_len, group_finish, packet_finish, overflow, dbg_state
  );
endinterface

// File: rtl/dap_resp_framer_stats.sv
// Wrapping packet/byte counters fed by the framer's finish pulses.
module dap_resp_framer_stats
  import dap_usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        group_finish,
  input  logic        packet_finish,
  input  dap_len_t    packet_len,
  output logic [15:0] stat_pkts,
  output logic [31:0] stat_bytes
);
  logic [15:0] pkts_q;
  logic [31:0] bytes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q  <= '0;
      bytes_q <= '0;
    end else begin
      if (packet_finish) pkts_q  <= pkts_q + 16'd1;
      if (group_finish)  bytes_q <= bytes_q + 32'(packet_len);
    end
  end

  assign stat_pkts  = pkts_q;
  assign stat_bytes = bytes_q;
endmodule

// File: rtl/dap_resp_framer.sv
// Frames DAP response bytes into group-relative packer RAM writes with finish pulses.
// Optional DAP_FRAMER_STATS_EN adds stat_pkts/stat_bytes counters.
module dap_resp_framer
  import dap_usb_pkg::*;
#(
  parameter int MAX_PKT_LEN = DAP_MAX_PKT_LEN_HS
)(
  input  logic                clk,
  input  logic                rst,
  dap_resp_framer_if.slave    bus
`ifdef DAP_FRAMER_STATS_EN
  ,
  output logic [15:0]         stat_pkts,
  output logic [31:0]         stat_bytes
`endif
);
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_GFIN   = GFIN;
  localparam logic [1:0] ST_PFIN   = PFIN;

  logic [1:0] state_q, state_d;
  dap_len_t   grp_cnt_q, grp_cnt_d;
  dap_len_t   pkt_cnt_q, pkt_cnt_d;
  logic       plast_q, plast_d;
  logic       ovf_q, ovf_d;
  logic       wr_en_q, wr_en_d;
  dap_len_t   wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  dap_len_t   len_q, len_d;
  logic       gfin_q, gfin_d;
  logic       pfin_q, pfin_d;

  logic s_ready;
  logic accept;
  logic in_limit;

  // almost_full only holds off the first byte of a packet
  assign s_ready  = (state_q == ST_STREAM) &&
                    !((pkt_cnt_q == '0) && (grp_cnt_q == '0) && bus.almost_full);
  assign accept   = bus.s_valid && s_ready;
  assign in_limit = ({1'b0, pkt_cnt_q} + {1'b0, grp_cnt_q}) < 11'(MAX_PKT_LEN);

  always_comb begin
    state_d   = state_q;
    grp_cnt_d = grp_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    plast_d   = plast_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    len_d     = '0;
    gfin_d    = 1'b0;
    pfin_d    = 1'b0;
    case (state_q)
      ST_STREAM: begin
        if (accept) begin
          if (in_limit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = grp_cnt_q;
            wr_data_d = bus.s_data;
            grp_cnt_d = grp_cnt_q + 10'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (bus.s_group_last || bus.s_packet_last) begin
            gfin_d  = 1'b1;
            len_d   = grp_cnt_d;
            plast_d = bus.s_packet_last;
            state_d = ST_GFIN;
          end
        end
      end
      ST_GFIN: begin
        pkt_cnt_d = pkt_cnt_q + grp_cnt_q;
        grp_cnt_d = '0;
        if (plast_q) begin
          pfin_d  = 1'b1;
          plast_d = 1'b0;
          state_d = ST_PFIN;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_PFIN: begin
        pkt_cnt_d = '0;
        state_d   = ST_STREAM;
      end
      default: state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STREAM;
      grp_cnt_q <= '0;
      pkt_cnt_q <= '0;
      plast_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q     <= '0;
      gfin_q    <= 1'b0;
      pfin_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_cnt_q <= grp_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      plast_q   <= plast_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_q     <= len_d;
      gfin_q    <= gfin_d;
      pfin_q    <= pfin_d;
    end
  end

  assign bus.s_ready        = s_ready;
  assign bus.ram_write_en   = wr_en_q;
  assign bus.ram_write_addr = wr_addr_q;
  assign bus.ram_write_data = wr_data_q;
  assign bus.packet_len     = len_q;
  assign bus.group_finish   = gfin_q;
  assign bus.packet_finish  = pfin_q;
  assign bus.overflow       = ovf_q;
  assign bus.dbg_state      = state_q;

`ifdef DAP_FRAMER_STATS_EN
  dap_resp_framer_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .group_finish (gfin_q),
    .packet_finish(pfin_q),
    .packet_len   (len_q),
    .stat_pkts    (stat_pkts),
    .stat_bytes   (stat_bytes)
  );
`endif
endmodule
